// File: rtl/uart_rx_fifo.sv
// UART receive front end: 8N1 LSB-first deserialiser feeding a small byte FIFO.
// The line passes a two-flop synchroniser before any decision is made on it.
// Handshake: the FIFO head is offered on d_rx while vld_rx=1; a byte is consumed
// on every rising clk edge where vld_rx && rdy_rx. rdy_rx is ignored while vld_rx=0,
// and d_rx is held stable while vld_rx && !rdy_rx.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    input  logic       rdy_rx,
    output logic [7:0] d_rx,
    output logic       vld_rx,
    output logic       frame_err,
    output logic       ovf_err,
    output logic       busy
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CYC_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CYC_W-1:0] cyc, cyc_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             push_set, ferr_set;
    logic             push_req;
    logic             rxd_m, rxd_s;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0] count, count_nx, count_after_pop;
    logic             pop, full, do_write, drop, bypass;
    logic [7:0]       head_nx;

    // Two-flop synchroniser; idle-high reset value so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cyc       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cyc       <= cyc_next;
            bit_idx   <= bit_next;
            shift     <= shift_next;
            push_req  <= push_set;
            frame_err <= ferr_set;
        end
    end

    // Next-state logic: half-bit wait validates the start bit, then full-bit
    // spacing lands every later sample near the bit centre. STOP returns to
    // IDLE at its sample point so a start bit directly after is not missed.
    always_comb begin
        state_next = state;
        cyc_next   = cyc + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        push_set   = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                cyc_next = '0;
                if (!rxd_s) state_next = START;
            end
            START: begin
                if (cyc == HALF_LAST) begin
                    cyc_next   = '0;
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cyc == BIT_LAST) begin
                    cyc_next   = '0;
                    shift_next = {rxd_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cyc == BIT_LAST) begin
                    cyc_next   = '0;
                    state_next = IDLE;
                    if (rxd_s) push_set = 1'b1;
                    else       ferr_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // FIFO control. A pop in the same cycle frees the slot, so a push onto a
    // full FIFO is only dropped when nothing is popped at that edge.
    always_comb begin
        pop             = vld_rx && rdy_rx;
        full            = (count == FULL_CNT);
        do_write        = push_req && (!full || pop);
        drop            = push_req && full && !pop;
        rd_ptr_nx       = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_after_pop = pop ? count - 1'b1 : count;
        count_nx        = do_write ? count_after_pop + 1'b1 : count_after_pop;
        // When the byte being written becomes the head, take it straight from the shifter.
        bypass          = do_write && (count_after_pop == '0);
        head_nx         = bypass ? shift : mem[rd_ptr_nx];
    end

    // Pointers, occupancy and the registered head/valid outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            vld_rx  <= 1'b0;
            d_rx    <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_nx;
            count   <= count_nx;
            vld_rx  <= (count_nx != '0);
            d_rx    <= (count_nx != '0) ? head_nx : 8'h00;
            ovf_err <= drop;
        end
    end

    // Byte storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= shift;
    end

endmodule
